// File: rtl/seg_disp_sched_if.sv
// rtl/seg_disp_sched_if.sv - client A/B valid/ready update bus for the display scheduler
interface seg_disp_sched_if;
  logic [23:0] i_a_data;
  logic        i_a_valid;
  logic        o_a_ready;
  logic [23:0] i_b_data;
  logic        i_b_valid;
  logic        o_b_ready;

  modport master (
    output i_a_data, i_a_valid, i_b_data, i_b_valid,
    input  o_a_ready, o_b_ready
  );

  modport slave (
    input  i_a_data, i_a_valid, i_b_data, i_b_valid,
    output o_a_ready, o_b_ready
  );
endinterface

// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - A/B display arbiter with frame-aligned updates and 6-digit scan
module seg_disp_sched #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_FRAMES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  seg_disp_sched_if.slave   bus,
  output logic              o_src,
  output logic [7:0]        SEG,
  output logic [5:0]        DIG
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {SHOW_A = 1'b0, SHOW_B = 1'b1} state_t;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  state_t        r_state;
  logic [23:0]   r_disp;
  logic [23:0]   r_shadow;
  logic [23:0]   r_a_slot;
  logic [23:0]   r_b_slot;
  logic          r_a_pend;
  logic          r_b_pend;
  logic [HW-1:0] r_hold;
  logic          r_src;
  logic [7:0]    r_seg;
  logic [5:0]    r_dig;

  logic          w_tick;
  logic          w_frame;
  logic          w_a_xfer;
  logic          w_b_xfer;
  logic [3:0]    w_nib;

  function automatic logic [7:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 8'h3F;  4'h1: f_hex7 = 8'h06;
      4'h2: f_hex7 = 8'h5B;  4'h3: f_hex7 = 8'h4F;
      4'h4: f_hex7 = 8'h66;  4'h5: f_hex7 = 8'h6D;
      4'h6: f_hex7 = 8'h7D;  4'h7: f_hex7 = 8'h07;
      4'h8: f_hex7 = 8'h7F;  4'h9: f_hex7 = 8'h6F;
      4'hA: f_hex7 = 8'h77;  4'hB: f_hex7 = 8'h7C;
      4'hC: f_hex7 = 8'h39;  4'hD: f_hex7 = 8'h5E;
      4'hE: f_hex7 = 8'h79;  default: f_hex7 = 8'h71;
    endcase
  endfunction

  assign w_tick   = (r_presc == PW'(SCAN_DIV - 1));
  assign w_frame  = w_tick && (r_idx == 3'd5);
  assign w_a_xfer = bus.i_a_valid && !r_a_pend;
  assign w_b_xfer = bus.i_b_valid && !r_b_pend;
  assign w_nib    = 4'(r_disp >> {r_idx, 2'b00});

  assign bus.o_a_ready = ~r_a_pend;
  assign bus.o_b_ready = ~r_b_pend;
  assign o_src = r_src;
  assign SEG   = r_seg;
  assign DIG   = r_dig;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_seg   <= '0;
      r_dig   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      r_seg <= f_hex7(w_nib);
      r_dig <= 6'b000001 << r_idx;
    end
  end

  // A new transfer can never coincide with consumption of the same slot, since
  // transfer needs pending low and consumption needs it high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= SHOW_A;
      r_src    <= 1'b0;
      r_disp   <= '0;
      r_shadow <= '0;
      r_a_slot <= '0;
      r_b_slot <= '0;
      r_a_pend <= 1'b0;
      r_b_pend <= 1'b0;
      r_hold   <= '0;
    end else begin
      if (w_a_xfer) begin
        r_a_slot <= bus.i_a_data;
        r_a_pend <= 1'b1;
      end
      if (w_b_xfer) begin
        r_b_slot <= bus.i_b_data;
        r_b_pend <= 1'b1;
      end
      if (w_frame) begin
        if (r_b_pend) begin
          r_disp   <= r_b_slot;
          r_hold   <= HW'(HOLD_FRAMES);
          r_b_pend <= 1'b0;
          r_state  <= SHOW_B;
          r_src    <= 1'b1;
        end else if (r_state == SHOW_B && r_hold > HW'(1)) begin
          r_hold <= r_hold - 1'b1;
        end else if (r_state == SHOW_B) begin
          r_state <= SHOW_A;
          r_src   <= 1'b0;
          r_hold  <= '0;
          if (r_a_pend) begin
            r_shadow <= r_a_slot;
            r_disp   <= r_a_slot;
            r_a_pend <= 1'b0;
          end else begin
            r_disp <= r_shadow;
          end
        end else if (r_a_pend) begin
          r_shadow <= r_a_slot;
          r_disp   <= r_a_slot;
          r_a_pend <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb/tb_seg_disp_sched.sv - directed and random checks of seg_disp_sched against a frame-level model
module tb_seg_disp_sched;
  localparam int SD    = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       src;
  logic [7:0] seg;
  logic [5:0] dig;

  seg_disp_sched_if bus ();

  seg_disp_sched #(.SCAN_DIV(SD), .HOLD_FRAMES(HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_src(src), .SEG(seg), .DIG(dig)
  );

  always #5 clk = ~clk;

  logic [7:0] hex7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time since reset decides the scanned digit; content is tracked per frame.
  int          n;
  logic [23:0] shown, shadow, pa, pb;
  logic        pa_v, pb_v, in_b;
  int          left;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; shown = '0; shadow = '0; pa = '0; pb = '0;
    pa_v = 0; pb_v = 0; in_b = 0; left = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_seg", 24'(seg), 24'h0);
    check("rst_dig", 24'(dig), 24'h0);
    check("rst_src", 24'(src), 24'h0);
    check("rst_a_ready", 24'(bus.o_a_ready), 24'h1);
    check("rst_b_ready", 24'(bus.o_b_ready), 24'h1);
  endtask

  task automatic step();
    logic       xa, xb;
    int         d;
    logic [3:0] nib;
    logic [7:0] exp_seg;
    logic [5:0] exp_dig;
    @(posedge clk);
    xa = bus.i_a_valid && !pa_v;
    xb = bus.i_b_valid && !pb_v;
    d = (n / SD) % 6;
    nib = shown[4*d +: 4];
    exp_seg = hex7[nib];
    exp_dig = 6'(1 << d);
    if (n % FRAME == FRAME - 1) begin
      if (pb_v) begin
        shown = pb; in_b = 1; left = HOLD; pb_v = 0;
      end else if (in_b) begin
        left--;
        if (left == 0) begin
          in_b = 0;
          if (pa_v) begin shadow = pa; shown = pa; pa_v = 0; end
          else shown = shadow;
        end
      end else if (pa_v) begin
        shadow = pa; shown = pa; pa_v = 0;
      end
    end
    if (xa) begin pa = bus.i_a_data; pa_v = 1; end
    if (xb) begin pb = bus.i_b_data; pb_v = 1; end
    n++;
    #1;
    check("seg", 24'(seg), 24'(exp_seg));
    check("dig", 24'(dig), 24'(exp_dig));
    check("src", 24'(src), 24'(in_b));
    check("a_ready", 24'(bus.o_a_ready), 24'(!pa_v));
    check("b_ready", 24'(bus.o_b_ready), 24'(!pb_v));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic send_a(input logic [23:0] v);
    bus.i_a_data = v; bus.i_a_valid = 1; step(); bus.i_a_valid = 0;
  endtask

  task automatic send_b(input logic [23:0] v);
    bus.i_b_data = v; bus.i_b_valid = 1; step(); bus.i_b_valid = 0;
  endtask

  task automatic wait_b_shown();
    int k;
    k = 0;
    while (!in_b && k < 4 * FRAME) begin step(); k++; end
    check("wait_b_shown_timeout", 24'(in_b), 24'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bus.i_a_data = '0; bus.i_a_valid = 0;
    bus.i_b_data = '0; bus.i_b_valid = 0;
    model_reset();

    // 1: reset and idle frame
    do_reset();
    run(FRAME);

    // 2: A update lands at next boundary
    send_a(24'h123456);
    run(2 * FRAME);

    // 3: B message overlays A for HOLD frames
    send_b(24'hEEEEEE);
    run(4 * FRAME);

    // 4: A held off during B hold; valid left high while back-pressured
    send_b(24'h111111);
    wait_b_shown();
    run(5);
    bus.i_a_data = 24'h000009; bus.i_a_valid = 1;
    run(2 * FRAME);
    bus.i_a_valid = 0;
    run(2 * FRAME);

    // 5: second B during the first hold frame restarts the hold
    send_b(24'hBBBBBB);
    wait_b_shown();
    run(5);
    send_b(24'hCCCCCC);
    run(4 * FRAME);

    // 6: asynchronous reset mid-hold, prescaler mid-slot
    send_a(24'hABCDEF);
    run(2 * FRAME);
    send_b(24'h987654);
    wait_b_shown();
    run(6);
    while (n % SD != 2) step();
    check("pre_rst_src", 24'(src), 24'h1);
    #1;
    rst_n = 0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run(FRAME);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.i_a_valid = ($urandom_range(0, 7) == 0);
      bus.i_a_data  = 24'($urandom);
      bus.i_b_valid = ($urandom_range(0, 79) == 0);
      bus.i_b_data  = 24'($urandom);
      step();
    end
    bus.i_a_valid = 0; bus.i_b_valid = 0;
    run(4 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
